// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder:
// opcodes, descriptor kinds and instruction field positions.
package isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   typedef enum logic [2:0] {
      KIND_R    = 3'd0,
      KIND_J    = 3'd1,
      KIND_ANDI = 3'd2,
      KIND_SW   = 3'd3,
      KIND_LW   = 3'd4,
      KIND_ADDI = 3'd5,
      KIND_BEQ  = 3'd6,
      KIND_BNE  = 3'd7
   } kind_e;

   localparam int OP_LSB     = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_LSB    = 0;
   localparam int TARGET_LSB = 0;

   // Opcode for the I-type kinds; R-type and j are packed separately.
   function automatic logic [5:0] itype_op(input kind_e kind);
      case (kind)
         KIND_ANDI: itype_op = OP_ANDI;
         KIND_SW:   itype_op = OP_SW;
         KIND_LW:   itype_op = OP_LW;
         KIND_ADDI: itype_op = OP_ADDI;
         KIND_BEQ:  itype_op = OP_BEQ;
         KIND_BNE:  itype_op = OP_BNE;
         default:   itype_op = OP_RTYPE;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor stream between the program source and the instruction encoder.
interface instr_encoder_if;
   import isa_pkg::*;

   logic        in_valid;
   logic        in_ready;
   kind_e       in_kind;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_target, in_last,
      output in_ready
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: maps a descriptor kind plus its fields to a 32-bit MIPS word.
module instr_pack
   import isa_pkg::*;
(
   input  kind_e       kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word
);

   // Pack by field position; fields a kind does not use never reach the word.
   always_comb begin
      word = 32'd0;
      case (kind)
         KIND_R: word = (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB)
                      | (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB)
                      | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
         KIND_J: word = (32'(OP_J) << OP_LSB) | (32'(target) << TARGET_LSB);
         KIND_ANDI, KIND_SW, KIND_LW, KIND_ADDI, KIND_BEQ, KIND_BNE:
                 word = (32'(itype_op(kind)) << OP_LSB) | (32'(rs) << RS_LSB)
                      | (32'(rt) << RT_LSB) | (32'(imm) << IMM_LSB);
         default: word = 32'd0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, encodes them and writes consecutive
// instruction-memory words until the last descriptor or the memory is full.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   instr_encoder_if.slave    in_bus,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              full
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1'b1);

   state_e              state_r;
   state_e              state_s;
   logic                in_ready_s;
   logic                accept_s;
   logic                fill_s;
   logic [31:0]         word_s;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W:0]     count_r;
   logic                done_r;
   logic                full_r;
   logic                imem_we_r;
   logic [ADDR_W-1:0]   imem_addr_r;
   logic [31:0]         imem_wdata_r;

   instr_pack u_pack (
      .kind   (in_bus.in_kind),
      .rs     (in_bus.in_rs),
      .rt     (in_bus.in_rt),
      .rd     (in_bus.in_rd),
      .shamt  (in_bus.in_shamt),
      .funct  (in_bus.in_funct),
      .imm    (in_bus.in_imm),
      .target (in_bus.in_target),
      .word   (word_s)
   );

   assign accept_s = in_ready_s && in_bus.in_valid;
   // This accept takes the last free word.
   assign fill_s   = (count_r + CNT_ONE_C) == DEPTH_C;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and ready; start wins in every state and blocks the beat in its cycle.
   always_comb begin
      state_s    = state_r;
      in_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            in_ready_s = !full_r && !start;
            if (start) begin
               state_s = ST_LOAD;
            end else if (accept_s && (in_bus.in_last || fill_s)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Write port, pointer and progress flags, all registered on the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r     <= {ADDR_W{1'b0}};
         count_r      <= {(ADDR_W+1){1'b0}};
         done_r       <= 1'b0;
         full_r       <= 1'b0;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= {ADDR_W{1'b0}};
         imem_wdata_r <= 32'd0;
      end else if (start) begin
         wr_ptr_r  <= {ADDR_W{1'b0}};
         count_r   <= {(ADDR_W+1){1'b0}};
         done_r    <= 1'b0;
         full_r    <= 1'b0;
         imem_we_r <= 1'b0;
      end else begin
         imem_we_r <= accept_s;
         if (accept_s) begin
            imem_addr_r  <= wr_ptr_r;
            imem_wdata_r <= word_s;
            wr_ptr_r     <= wr_ptr_r + PTR_ONE_C;
            count_r      <= count_r + CNT_ONE_C;
            done_r       <= in_bus.in_last || fill_s;
            full_r       <= fill_s;
         end else begin
            imem_addr_r  <= imem_addr_r;
            imem_wdata_r <= imem_wdata_r;
         end
      end
   end

   assign in_bus.in_ready = in_ready_s;
   assign imem_we         = imem_we_r;
   assign imem_addr       = imem_addr_r;
   assign imem_wdata      = imem_wdata_r;
   assign count           = count_r;
   assign done            = done_r;
   assign full            = full_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a full-size loader and a 4-word loader.
module tb_instr_encoder;
   import isa_pkg::*;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [8:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start8, start2;
   instr_encoder_if bus8();
   instr_encoder_if bus2();

   logic        we8, done8, full8;
   logic [7:0]  addr8;
   logic [31:0] wd8;
   logic [8:0]  cnt8;
   logic        we2, done2, full2;
   logic [1:0]  addr2;
   logic [31:0] wd2;
   logic [2:0]  cnt2;

   instr_encoder #(.ADDR_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .in_bus(bus8),
      .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
      .count(cnt8), .done(done8), .full(full8)
   );

   instr_encoder #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .in_bus(bus2),
      .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
      .count(cnt2), .done(done2), .full(full2)
   );

   exp_t q8[$];
   exp_t q2[$];
   exp_t e8, e2;
   int checks = 0;
   int passes = 0;
   logic [7:0] ptr8;
   logic [8:0] ecnt8;
   logic [1:0] ptr2;
   logic [8:0] ecnt2;
   logic [4:0] r_rs, r_rt, r_rd, r_sh;
   logic [5:0] r_fn;
   logic [15:0] r_imm;
   logic [25:0] r_tg;
   kind_e r_k;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_enc(input kind_e k, input logic [4:0] rs, rt, rd, sh,
                                           input logic [5:0] fn, input logic [15:0] imm,
                                           input logic [25:0] tg);
      logic [5:0] op;
      case (k)
         KIND_R:    return {6'b000000, rs, rt, rd, sh, fn};
         KIND_J:    return {6'b000010, tg};
         KIND_ANDI: op = 6'b001100;
         KIND_SW:   op = 6'b101011;
         KIND_LW:   op = 6'b100011;
         KIND_ADDI: op = 6'b001000;
         KIND_BEQ:  op = 6'b000100;
         default:   op = 6'b000101;
      endcase
      return {op, rs, rt, imm};
   endfunction

   // Monitors: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (we8 === 1'b1) begin
         if (q8.size() == 0) chk("dut8 unexpected strobe", 32'd1, 32'd0);
         else begin
            e8 = q8.pop_front();
            chk("dut8 addr", {24'd0, addr8}, {24'd0, e8.addr});
            chk("dut8 wdata", wd8, e8.wdata);
            chk("dut8 count", {23'd0, cnt8}, {23'd0, e8.cnt});
         end
      end
   end

   always @(negedge clk) begin
      if (we2 === 1'b1) begin
         if (q2.size() == 0) chk("dut2 unexpected strobe", 32'd1, 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("dut2 addr", {30'd0, addr2}, {24'd0, e2.addr});
            chk("dut2 wdata", wd2, e2.wdata);
            chk("dut2 count", {29'd0, cnt2}, {23'd0, e2.cnt});
         end
      end
   end

   task automatic send8(input kind_e k, input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg, input logic last,
                        input logic [31:0] exp_w);
      bit acc = 1'b0;
      bus8.in_kind = k; bus8.in_rs = rs; bus8.in_rt = rt; bus8.in_rd = rd;
      bus8.in_shamt = sh; bus8.in_funct = fn; bus8.in_imm = imm; bus8.in_target = tg;
      bus8.in_last = last; bus8.in_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (bus8.in_ready === 1'b1) begin
            q8.push_back(exp_t'{addr: ptr8, wdata: exp_w, cnt: ecnt8 + 9'd1});
            ptr8 = ptr8 + 8'd1;
            ecnt8 = ecnt8 + 9'd1;
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!acc) chk("dut8 accept timeout", 32'd0, 32'd1);
   endtask

   task automatic send2(input logic [31:0] exp_w);
      bit acc = 1'b0;
      bus2.in_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (bus2.in_ready === 1'b1) begin
            q2.push_back(exp_t'{addr: {6'd0, ptr2}, wdata: exp_w, cnt: ecnt2 + 9'd1});
            ptr2 = ptr2 + 2'd1;
            ecnt2 = ecnt2 + 9'd1;
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!acc) chk("dut2 accept timeout", 32'd0, 32'd1);
   endtask

   task automatic idle8(input int n);
      bus8.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_8();
      start8 = 1'b1;
      @(negedge clk);
      chk("dut8 ready in start cycle", {31'd0, bus8.in_ready}, 32'd0);
      @(posedge clk); #1;
      start8 = 1'b0;
      ptr8 = 8'd0;
      ecnt8 = 9'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
      ptr8 = 8'd0; ecnt8 = 9'd0; ptr2 = 2'd0; ecnt2 = 9'd0;
      bus8.in_valid = 1'b0; bus8.in_kind = KIND_R; bus8.in_rs = 5'd0; bus8.in_rt = 5'd0;
      bus8.in_rd = 5'd0; bus8.in_shamt = 5'd0; bus8.in_funct = 6'd0; bus8.in_imm = 16'd0;
      bus8.in_target = 26'd0; bus8.in_last = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_kind = KIND_LW; bus2.in_rs = 5'd29; bus2.in_rt = 5'd8;
      bus2.in_rd = 5'd0; bus2.in_shamt = 5'd0; bus2.in_funct = 6'd0; bus2.in_imm = 16'd4;
      bus2.in_target = 26'd0; bus2.in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("reset we", {31'd0, we8}, 32'd0);
      chk("reset addr", {24'd0, addr8}, 32'd0);
      chk("reset wdata", wd8, 32'd0);
      chk("reset count", {23'd0, cnt8}, 32'd0);
      chk("reset done/full", {30'd0, done8, full8}, 32'd0);
      chk("reset ready", {31'd0, bus8.in_ready}, 32'd0);
      chk("dut2 reset ready", {31'd0, bus2.in_ready}, 32'd0);
      @(posedge clk); #1;

      // Single addi
      start_8();
      send8(KIND_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 32'h20220005);
      idle8(3);

      // Back-to-back program ending in a last beat
      start_8();
      send8(KIND_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 32'h00221820);
      send8(KIND_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b0, 32'h08000010);
      send8(KIND_BNE, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 32'h1485FFFF);
      @(negedge clk);
      chk("last done", {31'd0, done8}, 32'd1);
      chk("last ready", {31'd0, bus8.in_ready}, 32'd0);
      chk("last count", {23'd0, cnt8}, 32'd3);
      chk("last full", {31'd0, full8}, 32'd0);
      @(posedge clk); #1;
      idle8(2);

      // start while a beat is offered in LOAD
      start_8();
      send8(KIND_ANDI, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0, 32'h306400FF);
      send8(KIND_SW, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, 32'hAFBF0008);
      bus8.in_kind = KIND_BEQ; bus8.in_rs = 5'd6; bus8.in_rt = 5'd7; bus8.in_imm = 16'hFFFE;
      start_8();
      send8(KIND_BEQ, 5'd6, 5'd7, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, 32'h10C7FFFE);
      idle8(2);

      // rst one cycle after an accept
      start_8();
      send8(KIND_LW, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h8C430010);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post-rst we", {31'd0, we8}, 32'd0);
         chk("post-rst ready", {31'd0, bus8.in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("post-rst addr", {24'd0, addr8}, 32'd0);
      chk("post-rst wdata", wd8, 32'd0);
      chk("post-rst count", {23'd0, cnt8}, 32'd0);
      chk("post-rst done/full", {30'd0, done8, full8}, 32'd0);
      @(posedge clk); #1;
      idle8(1);

      // Reference encoder over all kinds with gaps in valid
      start_8();
      for (int n = 0; n < 24; n++) begin
         r_k = kind_e'(3'((n * 5 + 3) % 8));
         r_rs = 5'($urandom); r_rt = 5'($urandom); r_rd = 5'($urandom); r_sh = 5'($urandom);
         r_fn = 6'($urandom); r_imm = 16'($urandom); r_tg = 26'($urandom);
         if ($urandom_range(0, 2) == 0) idle8($urandom_range(1, 2));
         send8(r_k, r_rs, r_rt, r_rd, r_sh, r_fn, r_imm, r_tg, n == 23,
               ref_enc(r_k, r_rs, r_rt, r_rd, r_sh, r_fn, r_imm, r_tg));
      end
      @(negedge clk);
      chk("random done", {31'd0, done8}, 32'd1);
      chk("random count", {23'd0, cnt8}, 32'd24);
      @(posedge clk); #1;
      idle8(2);

      // Four-word memory: fill, then the fifth beat must wait forever
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int i = 0; i < 4; i++) send2(32'h8FA80004);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dut2 fifth beat ready", {31'd0, bus2.in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("dut2 full", {31'd0, full2}, 32'd1);
      chk("dut2 done", {31'd0, done2}, 32'd1);
      chk("dut2 count", {29'd0, cnt2}, 32'd4);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      chk("dut8 pending writes", q8.size(), 32'd0);
      chk("dut2 pending writes", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
